full_cache_ctrl: RTL and testbench



---
 rtl/full_cache_ctrl_if.sv | 27 ++
 rtl/full_cache_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_full_cache_ctrl.sv | 395 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/full_cache_ctrl_if.sv
// full_cache_ctrl_if: system-bus request/response and RAM line-burst signals of the cache.
// The cache connects through the slave modport; the requester/RAM side uses master.
interface full_cache_ctrl_if;
  logic [15:0] sys_addr;
  logic [31:0] sys_wdata;
  logic [3:0]  sys_bval;
  logic        sys_rd;
  logic        sys_wr;
  logic [31:0] sys_rdata;
  logic        sys_ack;
  logic [12:0] ram_addr;
  logic [15:0] ram_wdata;
  logic        ram_avalid;
  logic        ram_rnw;
  logic [15:0] ram_rdata;
  logic        ram_rack;

  modport master (
    output sys_addr, sys_wdata, sys_bval, sys_rd, sys_wr, ram_rdata, ram_rack,
    input  sys_rdata, sys_ack, ram_addr, ram_wdata, ram_avalid, ram_rnw
  );

  modport slave (
    input  sys_addr, sys_wdata, sys_bval, sys_rd, sys_wr, ram_rdata, ram_rack,
    output sys_rdata, sys_ack, ram_addr, ram_wdata, ram_avalid, ram_rnw
  );
endinterface

// File: rtl/full_cache_ctrl.sv
// full_cache_ctrl: 4-way set-associative, write-through, write-allocate cache with true-LRU
// replacement between a 32-bit system bus and a 16-bit line-burst RAM (4 beats per 64-bit line).
module full_cache_ctrl (
  input  logic             cache_clk_i,
  input  logic             cache_not_reset_i,
  full_cache_ctrl_if.slave bus
);
  localparam int TAG_SIZE      = 5;
  localparam int INDEX_SIZE    = 8;
  localparam int OFFSET_SIZE   = 3;
  localparam int WORD_SIZE     = 32;
  localparam int RAM_WORD_SIZE = 16;
  localparam int LINE_WIDTH    = 64;
  localparam int NUM_SETS      = 1 << INDEX_SIZE;
  localparam int NUM_WAYS      = 4;

  typedef enum logic [2:0] {
    IDLE, LOOKUP, FILL_REQ, FILL, MERGE, WT_BEATS, WT_WAIT, ACK
  } state_t;

  state_t                     state_q;
  logic [15:2]                addr_q;
  logic [WORD_SIZE-1:0]       wdata_q;
  logic [3:0]                 bval_q;
  logic                       isWrite_q;
  logic [1:0]                 way_q;
  logic [1:0]                 beat_q;
  logic [LINE_WIDTH-1:0]      lineBuf_q;
  logic [WORD_SIZE-1:0]       sysRdata_q;
  logic                       sysAck_q;
  logic [12:0]                ramAddr_q;
  logic [RAM_WORD_SIZE-1:0]   ramWdata_q;
  logic                       ramAvalid_q;
  logic                       ramRnw_q;

  logic [NUM_WAYS-1:0]        valid_q [NUM_SETS];
  logic [1:0]                 age_q   [NUM_SETS][NUM_WAYS];
  logic [TAG_SIZE-1:0]        tag_q   [NUM_SETS][NUM_WAYS];
  logic [LINE_WIDTH-1:0]      data_q  [NUM_SETS][NUM_WAYS];

  logic [INDEX_SIZE-1:0]      setIdx;
  logic [TAG_SIZE-1:0]        tagIn;
  logic [12:0]                lineAddr;
  logic                       hit_d;
  logic [1:0]                 hitWay_d;
  logic [1:0]                 victim_d;
  logic [1:0]                 accessWay_d;
  logic                       foundFree_d;
  logic [LINE_WIDTH-1:0]      curLine_d;
  logic [LINE_WIDTH-1:0]      hitLine_d;
  logic [WORD_SIZE-1:0]       curWord_d;
  logic [WORD_SIZE-1:0]       hitWord_d;
  logic [WORD_SIZE-1:0]       mergedWord_d;
  logic [LINE_WIDTH-1:0]      mergedLine_d;
  logic                       unusedAddrBits;

  // The byte-in-word address bits carry no meaning on a word-wide bus.
  assign unusedAddrBits = ^bus.sys_addr[1:0];

  assign setIdx   = addr_q[OFFSET_SIZE +: INDEX_SIZE];
  assign tagIn    = addr_q[OFFSET_SIZE + INDEX_SIZE +: TAG_SIZE];
  assign lineAddr = addr_q[OFFSET_SIZE +: TAG_SIZE + INDEX_SIZE];

  assign bus.sys_rdata  = sysRdata_q;
  assign bus.sys_ack    = sysAck_q;
  assign bus.ram_addr   = ramAddr_q;
  assign bus.ram_wdata  = ramWdata_q;
  assign bus.ram_avalid = ramAvalid_q;
  assign bus.ram_rnw    = ramRnw_q;

  // Tag match, victim choice (first free way, else the oldest) and byte merge for the latched request.
  always_comb begin
    hit_d       = 1'b0;
    hitWay_d    = 2'd0;
    victim_d    = 2'd0;
    foundFree_d = 1'b0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!hit_d && valid_q[setIdx][w] && tag_q[setIdx][w] == tagIn) begin
        hit_d    = 1'b1;
        hitWay_d = 2'(w);
      end
    end
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!foundFree_d && !valid_q[setIdx][w]) begin
        foundFree_d = 1'b1;
        victim_d    = 2'(w);
      end
    end
    if (!foundFree_d) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (age_q[setIdx][w] == 2'd3) victim_d = 2'(w);
      end
    end
    accessWay_d = hit_d ? hitWay_d : victim_d;
    curLine_d   = data_q[setIdx][way_q];
    hitLine_d   = data_q[setIdx][hitWay_d];
    curWord_d   = addr_q[2] ? curLine_d[63:32] : curLine_d[31:0];
    hitWord_d   = addr_q[2] ? hitLine_d[63:32] : hitLine_d[31:0];
    for (int b = 0; b < 4; b++) begin
      mergedWord_d[8*b +: 8] = bval_q[b] ? wdata_q[8*b +: 8] : curWord_d[8*b +: 8];
    end
    mergedLine_d = addr_q[2] ? {mergedWord_d, curLine_d[31:0]} : {curLine_d[63:32], mergedWord_d};
  end

  // Request sequencing, line fill, write-through burst, LRU ageing and registered bus outputs.
  always_ff @(posedge cache_clk_i) begin
    if (!cache_not_reset_i) begin
      state_q     <= IDLE;
      sysAck_q    <= 1'b0;
      sysRdata_q  <= '0;
      ramAvalid_q <= 1'b0;
      ramRnw_q    <= 1'b1;
      ramAddr_q   <= '0;
      ramWdata_q  <= '0;
      beat_q      <= 2'd0;
      way_q       <= 2'd0;
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s]  <= '0;
        age_q[s][0] <= 2'd3;
        age_q[s][1] <= 2'd2;
        age_q[s][2] <= 2'd1;
        age_q[s][3] <= 2'd0;
      end
    end else begin
      sysAck_q    <= 1'b0;
      ramAvalid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.sys_rd || bus.sys_wr) begin
            addr_q    <= bus.sys_addr[15:2];
            wdata_q   <= bus.sys_wdata;
            bval_q    <= bus.sys_bval;
            isWrite_q <= bus.sys_wr;
            state_q   <= LOOKUP;
          end
        end
        LOOKUP: begin
          way_q <= accessWay_d;
          for (int w = 0; w < NUM_WAYS; w++) begin
            if (2'(w) == accessWay_d) begin
              age_q[setIdx][w] <= 2'd0;
            end else if (age_q[setIdx][w] < age_q[setIdx][accessWay_d]) begin
              age_q[setIdx][w] <= age_q[setIdx][w] + 2'd1;
            end
          end
          if (hit_d) begin
            if (isWrite_q) begin
              state_q <= MERGE;
            end else begin
              sysRdata_q <= hitWord_d;
              sysAck_q   <= 1'b1;
              state_q    <= ACK;
            end
          end else begin
            ramAvalid_q <= 1'b1;
            ramRnw_q    <= 1'b1;
            ramAddr_q   <= lineAddr;
            beat_q      <= 2'd0;
            state_q     <= FILL_REQ;
          end
        end
        FILL_REQ, FILL: begin
          if (state_q == FILL_REQ) state_q <= FILL;
          if (bus.ram_rack) begin
            lineBuf_q[{beat_q, 4'b0000} +: 16] <= bus.ram_rdata;
            beat_q <= beat_q + 2'd1;
            if (beat_q == 2'd3) begin
              data_q[setIdx][way_q]  <= {bus.ram_rdata, lineBuf_q[47:0]};
              tag_q[setIdx][way_q]   <= tagIn;
              valid_q[setIdx][way_q] <= 1'b1;
              state_q                <= MERGE;
            end
          end
        end
        MERGE: begin
          if (isWrite_q) begin
            data_q[setIdx][way_q] <= mergedLine_d;
            lineBuf_q             <= mergedLine_d;
            ramAvalid_q           <= 1'b1;
            ramRnw_q              <= 1'b0;
            ramAddr_q             <= lineAddr;
            ramWdata_q            <= mergedLine_d[15:0];
            beat_q                <= 2'd1;
            state_q               <= WT_BEATS;
          end else begin
            sysRdata_q <= curWord_d;
            sysAck_q   <= 1'b1;
            state_q    <= ACK;
          end
        end
        WT_BEATS: begin
          ramWdata_q <= lineBuf_q[{beat_q, 4'b0000} +: 16];
          beat_q     <= beat_q + 2'd1;
          if (beat_q == 2'd3) state_q <= WT_WAIT;
        end
        WT_WAIT: begin
          if (bus.ram_rack) begin
            sysAck_q <= 1'b1;
            state_q  <= ACK;
          end
        end
        ACK: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_full_cache_ctrl.sv
// tb_full_cache_ctrl: directed scenarios plus randomized traffic for full_cache_ctrl, checked
// against a behavioural model (per-set recency lists of tags over a flat line memory).
module tb_full_cache_ctrl;
  logic clk;
  logic notReset;
  int   vectors;
  int   misses;

  full_cache_ctrl_if bus ();

  full_cache_ctrl dut (
    .cache_clk_i       (clk),
    .cache_not_reset_i (notReset),
    .bus               (bus)
  );

  // Bench RAM contents and activity log
  logic [63:0] ramStore [8192];
  int          rdCmds;
  int          wrCmds;
  logic [12:0] rdAddrLog;
  logic [12:0] wrAddrLog;
  logic [63:0] wrLineLog;

  // Reference model: expected memory, MRU-first tag list per set, expected read data
  logic [63:0] modelMem [8192];
  logic [4:0]  mList [256][4];
  int          mCnt [256];
  logic [31:0] expRdata;

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run always ends
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [63:0] initLine(input logic [12:0] l);
    return {1'b0, 2'd3, l, 1'b0, 2'd2, l, 1'b0, 2'd1, l, 1'b0, 2'd0, l};
  endfunction

  // Bench RAM: answers line reads with beats (random gaps), collects write beats and acks them later
  initial begin
    int rdPend;
    int rdK;
    int rdWait;
    int wrCnt;
    int wrWait;
    logic [63:0] rdLine;
    logic [63:0] wrLine;
    rdPend = 0; rdK = 0; rdWait = 0; wrCnt = 0; wrWait = 0;
    rdLine = '0; wrLine = '0;
    bus.ram_rack  = 1'b0;
    bus.ram_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.ram_rack  = 1'b0;
      bus.ram_rdata = 16'($urandom);
      if (notReset !== 1'b1) begin
        rdPend = 0;
        wrCnt  = 0;
      end else begin
        if (bus.ram_avalid === 1'b1) begin
          if (bus.ram_rnw === 1'b1) begin
            rdCmds++;
            rdAddrLog = bus.ram_addr;
            rdLine    = ramStore[bus.ram_addr];
            rdPend    = 4;
            rdK       = 0;
            rdWait    = $urandom_range(0, 2);
          end else begin
            wrCmds++;
            wrAddrLog      = bus.ram_addr;
            wrLine[15:0]   = bus.ram_wdata;
            wrCnt          = 1;
          end
        end else if (wrCnt > 0 && wrCnt < 4) begin
          wrLine[16*wrCnt +: 16] = bus.ram_wdata;
          wrCnt++;
          if (wrCnt == 4) wrWait = $urandom_range(1, 3);
        end
        if (rdPend > 0) begin
          if (rdWait > 0) begin
            rdWait--;
          end else if ($urandom_range(0, 3) != 0) begin
            bus.ram_rack  = 1'b1;
            bus.ram_rdata = rdLine[16*rdK +: 16];
            rdK++;
            rdPend--;
          end
        end else if (wrCnt == 4) begin
          if (wrWait > 0) begin
            wrWait--;
          end else begin
            bus.ram_rack        = 1'b1;
            ramStore[wrAddrLog] = wrLine;
            wrLineLog           = wrLine;
            wrCnt               = 0;
          end
        end
      end
    end
  end

  task automatic modelReset();
    for (int s = 0; s < 256; s++) mCnt[s] = 0;
    expRdata = '0;
  endtask

  // Predicts hit/miss and resulting line; updates recency, memory and expected read data
  task automatic modelAccess(input bit isWr, input logic [15:0] a, input logic [31:0] d,
                             input logic [3:0] be, output bit hit, output logic [63:0] line);
    logic [7:0]  idx;
    logic [4:0]  tg;
    logic [12:0] la;
    logic [31:0] word;
    int          pos;
    idx = a[10:3];
    tg  = a[15:11];
    la  = a[15:3];
    pos = -1;
    for (int i = 0; i < mCnt[idx]; i++) if (mList[idx][i] == tg) pos = i;
    hit = (pos >= 0);
    if (!hit) begin
      if (mCnt[idx] < 4) mCnt[idx]++;
      pos = mCnt[idx] - 1;
    end
    for (int i = pos; i > 0; i--) mList[idx][i] = mList[idx][i-1];
    mList[idx][0] = tg;
    line = modelMem[la];
    word = a[2] ? line[63:32] : line[31:0];
    if (isWr) begin
      for (int b = 0; b < 4; b++) if (be[b]) word[8*b +: 8] = d[8*b +: 8];
      if (a[2]) line[63:32] = word;
      else      line[31:0]  = word;
      modelMem[la] = line;
    end else begin
      expRdata = word;
    end
  endtask

  // Issues one request, optionally fires ignored strobes while busy, and measures ack timing
  task automatic runAccess(input bit doRd, input bit doWr, input logic [15:0] a,
                           input logic [31:0] d, input logic [3:0] be, input bit spurious,
                           output int lat, output bit gotAck, output int extraAcks);
    @(negedge clk);
    bus.sys_addr  = a;
    bus.sys_wdata = d;
    bus.sys_bval  = be;
    bus.sys_rd    = doRd;
    bus.sys_wr    = doWr;
    @(negedge clk);
    bus.sys_rd    = 1'b0;
    bus.sys_wr    = 1'b0;
    bus.sys_addr  = 16'($urandom);
    bus.sys_wdata = $urandom;
    bus.sys_bval  = 4'($urandom);
    lat    = 1;
    gotAck = 1'b0;
    while (!gotAck && lat < 300) begin
      if (bus.sys_ack === 1'b1) begin
        gotAck = 1'b1;
      end else begin
        if (spurious && $urandom_range(0, 3) == 0) begin
          bus.sys_rd   = 1'($urandom);
          bus.sys_wr   = ~bus.sys_rd;
          bus.sys_addr = 16'($urandom);
        end else begin
          bus.sys_rd = 1'b0;
          bus.sys_wr = 1'b0;
        end
        @(negedge clk);
        lat++;
      end
    end
    bus.sys_rd = 1'b0;
    bus.sys_wr = 1'b0;
    extraAcks  = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.sys_ack !== 1'b0) extraAcks++;
    end
  endtask

  task automatic test_reset();
    notReset    = 1'b0;
    bus.sys_rd  = 1'b0;
    bus.sys_wr  = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if (bus.sys_ack !== 1'b0) begin misses++; $display("[TB] FAIL reset_ack: got %b expected 0", bus.sys_ack); end
    vectors++; if (bus.sys_rdata !== 32'h0) begin misses++; $display("[TB] FAIL reset_rdata: got %h expected 0", bus.sys_rdata); end
    vectors++; if (bus.ram_avalid !== 1'b0) begin misses++; $display("[TB] FAIL reset_avalid: got %b expected 0", bus.ram_avalid); end
    vectors++; if (bus.ram_rnw !== 1'b1) begin misses++; $display("[TB] FAIL reset_rnw: got %b expected 1", bus.ram_rnw); end
    vectors++; if (bus.ram_addr !== 13'h0) begin misses++; $display("[TB] FAIL reset_ram_addr: got %h expected 0", bus.ram_addr); end
    vectors++; if (bus.ram_wdata !== 16'h0) begin misses++; $display("[TB] FAIL reset_ram_wdata: got %h expected 0", bus.ram_wdata); end
    modelReset();
    @(negedge clk);
    notReset = 1'b1;
  endtask

  task automatic test_read_miss_hit();
    int lat, ex, rd0;
    bit ok, hit;
    logic [63:0] line;
    modelAccess(1'b0, 16'hABCD, 32'h0, 4'h0, hit, line);
    rd0 = rdCmds;
    runAccess(1'b1, 1'b0, 16'hABCD, 32'h0, 4'h0, 1'b0, lat, ok, ex);
    vectors++; if (ok !== 1'b1) begin misses++; $display("[TB] FAIL rdmiss_ack: got %b expected 1", ok); end
    vectors++; if (rdCmds - rd0 != 1) begin misses++; $display("[TB] FAIL rdmiss_cmds: got %0d expected 1", rdCmds - rd0); end
    vectors++; if (rdAddrLog !== 13'h1579) begin misses++; $display("[TB] FAIL rdmiss_addr: got %h expected 1579", rdAddrLog); end
    vectors++; if (bus.sys_rdata !== 32'h75795579) begin misses++; $display("[TB] FAIL rdmiss_data: got %h expected 75795579", bus.sys_rdata); end
    vectors++; if (ex != 0) begin misses++; $display("[TB] FAIL rdmiss_ack_width: got %0d extra acks expected 0", ex); end
    modelAccess(1'b0, 16'hABCD, 32'h0, 4'h0, hit, line);
    rd0 = rdCmds;
    runAccess(1'b1, 1'b0, 16'hABCD, 32'h0, 4'h0, 1'b0, lat, ok, ex);
    vectors++; if (rdCmds - rd0 != 0) begin misses++; $display("[TB] FAIL rdhit_cmds: got %0d expected 0", rdCmds - rd0); end
    vectors++; if (lat != 2) begin misses++; $display("[TB] FAIL rdhit_latency: got %0d expected 2", lat); end
    vectors++; if (bus.sys_rdata !== expRdata) begin misses++; $display("[TB] FAIL rdhit_data: got %h expected %h", bus.sys_rdata, expRdata); end
  endtask

  task automatic test_write_through();
    int lat, ex, rd0, wr0;
    bit ok, hit;
    logic [63:0] line;
    logic [15:0] addrs [3];
    logic [31:0] datas [3];
    logic [3:0]  bvals [3];
    logic [63:0] lines [3];
    addrs = '{16'hABCD, 16'hABC8, 16'hABCC};
    datas = '{32'hdeadbeef, 32'hdeadf00d, 32'hb44dc0d3};
    bvals = '{4'b1111, 4'b1111, 4'b1001};
    lines = '{64'hdeadbeef_35791579, 64'hdeadbeef_deadf00d, 64'hb4adbed3_deadf00d};
    for (int i = 0; i < 3; i++) begin
      modelAccess(1'b1, addrs[i], datas[i], bvals[i], hit, line);
      rd0 = rdCmds;
      wr0 = wrCmds;
      runAccess(1'b0, 1'b1, addrs[i], datas[i], bvals[i], 1'b0, lat, ok, ex);
      vectors++; if (ok !== 1'b1 || ex != 0) begin misses++; $display("[TB] FAIL wt_ack[%0d]: got ack=%b extra=%0d expected ack=1 extra=0", i, ok, ex); end
      vectors++; if (rdCmds != rd0 || wrCmds - wr0 != 1) begin misses++; $display("[TB] FAIL wt_cmds[%0d]: got rd=%0d wr=%0d expected rd=0 wr=1", i, rdCmds - rd0, wrCmds - wr0); end
      vectors++; if (wrAddrLog !== 13'h1579) begin misses++; $display("[TB] FAIL wt_addr[%0d]: got %h expected 1579", i, wrAddrLog); end
      vectors++; if (wrLineLog !== lines[i] || wrLineLog !== line) begin misses++; $display("[TB] FAIL wt_line[%0d]: got %h expected %h", i, wrLineLog, lines[i]); end
      vectors++; if (bus.sys_rdata !== 32'h75795579) begin misses++; $display("[TB] FAIL wt_rdata_held[%0d]: got %h expected 75795579", i, bus.sys_rdata); end
    end
  endtask

  task automatic test_write_miss();
    int lat, ex, rd0, wr0;
    bit ok, hit;
    logic [63:0] line;
    modelAccess(1'b1, 16'hBBCD, 32'hdeadbeef, 4'hF, hit, line);
    rd0 = rdCmds;
    wr0 = wrCmds;
    runAccess(1'b0, 1'b1, 16'hBBCD, 32'hdeadbeef, 4'hF, 1'b0, lat, ok, ex);
    vectors++; if (ok !== 1'b1) begin misses++; $display("[TB] FAIL wmiss_ack: got %b expected 1", ok); end
    vectors++; if (rdCmds - rd0 != 1 || rdAddrLog !== 13'h1779) begin misses++; $display("[TB] FAIL wmiss_fill: got %0d reads at %h expected 1 at 1779", rdCmds - rd0, rdAddrLog); end
    vectors++; if (wrCmds - wr0 != 1 || wrAddrLog !== 13'h1779) begin misses++; $display("[TB] FAIL wmiss_write: got %0d writes at %h expected 1 at 1779", wrCmds - wr0, wrAddrLog); end
    vectors++; if (wrLineLog !== 64'hdeadbeef_37791779) begin misses++; $display("[TB] FAIL wmiss_line: got %h expected deadbeef37791779", wrLineLog); end
    // Empty byte mask still writes the line through, unchanged
    modelAccess(1'b1, 16'hBBC8, 32'h12345678, 4'h0, hit, line);
    wr0 = wrCmds;
    runAccess(1'b0, 1'b1, 16'hBBC8, 32'h12345678, 4'h0, 1'b0, lat, ok, ex);
    vectors++; if (ok !== 1'b1 || wrCmds - wr0 != 1) begin misses++; $display("[TB] FAIL bval0_write: got ack=%b writes=%0d expected ack=1 writes=1", ok, wrCmds - wr0); end
    vectors++; if (wrLineLog !== 64'hdeadbeef_37791779) begin misses++; $display("[TB] FAIL bval0_line: got %h expected deadbeef37791779", wrLineLog); end
  endtask

  task automatic test_lru_evict();
    int lat, ex, rd0;
    bit ok, hit;
    logic [63:0] line;
    logic [31:0] d;
    logic [15:0] addrs [5];
    addrs = '{16'hA00C, 16'h700C, 16'h100C, 16'hF00C, 16'hE00C};
    for (int i = 0; i < 5; i++) begin
      d = $urandom;
      modelAccess(1'b1, addrs[i], d, 4'hF, hit, line);
      rd0 = rdCmds;
      runAccess(1'b0, 1'b1, addrs[i], d, 4'hF, 1'b0, lat, ok, ex);
      vectors++; if (rdCmds - rd0 != 1 || rdAddrLog !== addrs[i][15:3]) begin misses++; $display("[TB] FAIL lru_fill[%0d]: got %0d reads at %h expected 1 at %h", i, rdCmds - rd0, rdAddrLog, addrs[i][15:3]); end
      vectors++; if (wrLineLog !== line) begin misses++; $display("[TB] FAIL lru_line[%0d]: got %h expected %h", i, wrLineLog, line); end
    end
    modelAccess(1'b0, 16'hA008, 32'h0, 4'h0, hit, line);
    rd0 = rdCmds;
    runAccess(1'b1, 1'b0, 16'hA008, 32'h0, 4'h0, 1'b0, lat, ok, ex);
    vectors++; if (rdCmds - rd0 != 1 || rdAddrLog !== 13'h1401) begin misses++; $display("[TB] FAIL lru_evicted: got %0d reads at %h expected 1 at 1401", rdCmds - rd0, rdAddrLog); end
    vectors++; if (bus.sys_rdata !== 32'h34011401) begin misses++; $display("[TB] FAIL lru_evicted_data: got %h expected 34011401", bus.sys_rdata); end
    modelAccess(1'b0, 16'h1008, 32'h0, 4'h0, hit, line);
    rd0 = rdCmds;
    runAccess(1'b1, 1'b0, 16'h1008, 32'h0, 4'h0, 1'b0, lat, ok, ex);
    vectors++; if (rdCmds - rd0 != 0 || lat != 2) begin misses++; $display("[TB] FAIL lru_kept: got %0d reads latency %0d expected 0 reads latency 2", rdCmds - rd0, lat); end
    vectors++; if (bus.sys_rdata !== expRdata) begin misses++; $display("[TB] FAIL lru_kept_data: got %h expected %h", bus.sys_rdata, expRdata); end
  endtask

  task automatic test_reset_mid_fill();
    int lat, ex, rd0, waited, acks;
    bit ok, hit;
    logic [63:0] line;
    rd0 = rdCmds;
    acks = 0;
    @(negedge clk);
    bus.sys_addr = 16'h5550;
    bus.sys_rd   = 1'b1;
    @(negedge clk);
    bus.sys_rd   = 1'b0;
    waited = 0;
    while (rdCmds == rd0 && waited < 50) begin
      if (bus.sys_ack === 1'b1) acks++;
      @(negedge clk);
      waited++;
    end
    vectors++; if (rdCmds - rd0 != 1) begin misses++; $display("[TB] FAIL midfill_started: got %0d reads expected 1", rdCmds - rd0); end
    notReset = 1'b0;
    repeat (2) @(negedge clk);
    vectors++; if (bus.ram_avalid !== 1'b0) begin misses++; $display("[TB] FAIL midfill_avalid: got %b expected 0", bus.ram_avalid); end
    notReset = 1'b1;
    modelReset();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.sys_ack === 1'b1) acks++;
    end
    vectors++; if (acks != 0) begin misses++; $display("[TB] FAIL midfill_no_ack: got %0d acks expected 0", acks); end
    modelAccess(1'b0, 16'hABCD, 32'h0, 4'h0, hit, line);
    rd0 = rdCmds;
    runAccess(1'b1, 1'b0, 16'hABCD, 32'h0, 4'h0, 1'b0, lat, ok, ex);
    vectors++; if (rdCmds - rd0 != 1 || rdAddrLog !== 13'h1579) begin misses++; $display("[TB] FAIL midfill_cold: got %0d reads at %h expected 1 at 1579", rdCmds - rd0, rdAddrLog); end
    vectors++; if (bus.sys_rdata !== expRdata) begin misses++; $display("[TB] FAIL midfill_data: got %h expected %h", bus.sys_rdata, expRdata); end
  endtask

  task automatic test_random();
    int lat, ex, rd0, wr0, op;
    bit ok, hit, isWr;
    logic [63:0] line;
    logic [15:0] a;
    logic [31:0] d;
    logic [3:0]  be;
    for (int n = 0; n < 200; n++) begin
      a    = {5'($urandom_range(0, 5)), 7'h10, 1'($urandom), 3'($urandom)};
      d    = $urandom;
      be   = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
      op   = $urandom_range(0, 2);
      isWr = (op != 0);
      modelAccess(isWr, a, d, be, hit, line);
      rd0 = rdCmds;
      wr0 = wrCmds;
      runAccess(op != 1, op != 0, a, d, be, 1'b1, lat, ok, ex);
      vectors++; if (ok !== 1'b1 || ex != 0) begin misses++; $display("[TB] FAIL rnd_ack[%0d]: got ack=%b extra=%0d expected ack=1 extra=0", n, ok, ex); end
      vectors++; if (rdCmds - rd0 != (hit ? 0 : 1)) begin misses++; $display("[TB] FAIL rnd_fill[%0d]: got %0d reads expected %0d addr %h", n, rdCmds - rd0, hit ? 0 : 1, a); end
      vectors++; if (wrCmds - wr0 != (isWr ? 1 : 0)) begin misses++; $display("[TB] FAIL rnd_wcmd[%0d]: got %0d writes expected %0d", n, wrCmds - wr0, isWr ? 1 : 0); end
      if (isWr) begin
        vectors++; if (wrAddrLog !== a[15:3] || wrLineLog !== line) begin misses++; $display("[TB] FAIL rnd_wline[%0d]: got %h@%h expected %h@%h", n, wrLineLog, wrAddrLog, line, a[15:3]); end
      end
      if (!isWr && hit) begin
        vectors++; if (lat != 2) begin misses++; $display("[TB] FAIL rnd_hit_latency[%0d]: got %0d expected 2", n, lat); end
      end
      vectors++; if (bus.sys_rdata !== expRdata) begin misses++; $display("[TB] FAIL rnd_rdata[%0d]: got %h expected %h", n, bus.sys_rdata, expRdata); end
    end
  endtask

  // Scenario sequence and summary
  initial begin
    vectors       = 0;
    misses        = 0;
    rdCmds        = 0;
    wrCmds        = 0;
    rdAddrLog     = '0;
    wrAddrLog     = '0;
    wrLineLog     = '0;
    notReset      = 1'b0;
    bus.sys_addr  = '0;
    bus.sys_wdata = '0;
    bus.sys_bval  = '0;
    bus.sys_rd    = 1'b0;
    bus.sys_wr    = 1'b0;
    for (int l = 0; l < 8192; l++) begin
      ramStore[l] = initLine(13'(l));
      modelMem[l] = initLine(13'(l));
    end
    modelReset();
    test_reset();
    test_read_miss_hit();
    test_write_through();
    test_write_miss();
    test_lru_evict();
    test_reset_mid_fill();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end
endmodule
